// File: rtl/frame_scan_pkg.sv
// Shared types and constants for the frame scan counter.
// FSM state encoding, output port widths and default image geometry.
package frame_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COORD_W    = 15;
  localparam int CH_W       = 8;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 640;
  localparam int DEF_NUM_CH = 3;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter stage. The wrap output is combinational so that
// stages can be cascaded, and a whole chain rolls over in one edge.
module wrap_counter
  import frame_scan_pkg::*;
#(
  parameter int W = COORD_W,
  parameter int N = DEF_IMG_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = inc && (value == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/frame_scan_counter.sv
// Raster scan generator: col -> row -> ch cascade with line/plane/frame pulses.
// Optional macro FRAME_SCAN_AUTORESTART_EN loops straight back into RUN after each frame.
module frame_scan_counter
  import frame_scan_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               adv,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic [CH_W-1:0]    ch,
  output logic               busy,
  output logic               line_done,
  output logic               plane_done,
  output logic               frame_done
);

  state_t state;
  logic   run;
  logic   col_wrap;
  logic   row_wrap;
  logic   ch_wrap;

  assign run = (state == RUN);

  // Counters are held at zero outside RUN so every scan begins at the origin.
  wrap_counter #(.W(COORD_W), .N(IMG_W)) u_col (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!run),
    .inc     (run && adv),
    .value   (col),
    .wrap    (col_wrap)
  );

  wrap_counter #(.W(COORD_W), .N(IMG_H)) u_row (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!run),
    .inc     (col_wrap),
    .value   (row),
    .wrap    (row_wrap)
  );

  wrap_counter #(.W(CH_W), .N(NUM_CH)) u_ch (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!run),
    .inc     (row_wrap),
    .value   (ch),
    .wrap    (ch_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      line_done  <= 1'b0;
      plane_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      line_done  <= col_wrap;
      plane_done <= row_wrap;
      frame_done <= ch_wrap;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (ch_wrap) begin
`ifdef FRAME_SCAN_AUTORESTART_EN
            state <= RUN;
            busy  <= 1'b1;
`else
            state <= DONE;
            busy  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scan_counter.sv
// Testbench for frame_scan_counter with a 4x3x2 geometry.
// Expected outputs come from a behavioural scan model queued per driven cycle.
module tb_frame_scan_counter;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;
  localparam int NUM_CH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        adv;
  logic [14:0] col;
  logic [14:0] row;
  logic [7:0]  ch;
  logic        busy;
  logic        line_done;
  logic        plane_done;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;

  logic [41:0] sb[$];
  logic [41:0] exp_v;
  logic [41:0] act_v;

  int   m_state;
  int   m_col;
  int   m_row;
  int   m_ch;
  logic m_l;
  logic m_p;
  logic m_f;

  always #5 clk = ~clk;

  frame_scan_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .adv        (adv),
    .col        (col),
    .row        (row),
    .ch         (ch),
    .busy       (busy),
    .line_done  (line_done),
    .plane_done (plane_done),
    .frame_done (frame_done)
  );

  function automatic logic [41:0] observed();
    return {busy, line_done, plane_done, frame_done, ch, row, col};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_col   = 0;
    m_row   = 0;
    m_ch    = 0;
    m_l     = 1'b0;
    m_p     = 1'b0;
    m_f     = 1'b0;
  endtask

  // State encoding in the model: 0 idle, 1 run, 2 done.
  task automatic model_step(input logic s, input logic a);
    m_l = 1'b0;
    m_p = 1'b0;
    m_f = 1'b0;
    if (m_state == 1) begin
      if (a) begin
        if (m_col == IMG_W - 1) begin
          m_col = 0;
          m_l   = 1'b1;
          if (m_row == IMG_H - 1) begin
            m_row = 0;
            m_p   = 1'b1;
            if (m_ch == NUM_CH - 1) begin
              m_ch = 0;
              m_f  = 1'b1;
`ifdef FRAME_SCAN_AUTORESTART_EN
              m_state = 1;
`else
              m_state = 2;
`endif
            end else begin
              m_ch = m_ch + 1;
            end
          end else begin
            m_row = m_row + 1;
          end
        end else begin
          m_col = m_col + 1;
        end
      end
    end else if (s) begin
      m_state = 1;
      m_col   = 0;
      m_row   = 0;
      m_ch    = 0;
    end
  endtask

  task automatic drive_cycle(input logic s, input logic a);
    @(negedge clk);
    start = s;
    adv   = a;
    model_step(s, a);
    sb.push_back({(m_state == 1), m_l, m_p, m_f, 8'(m_ch), 15'(m_row), 15'(m_col)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    adv     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (observed() !== 42'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %h expected %h", observed(), 42'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_idle_adv();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1);
      exp_v = sb.pop_front();
      act_v = observed();
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL idle_adv[%0d]: got %h expected %h", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_full_frame();
    int n_line = 0;
    int n_plane = 0;
    int n_frame = 0;
    int frame_at = -1;
    logic exp_busy;
    drive_cycle(1'b1, 1'b0);
    exp_v = sb.pop_front();
    act_v = observed();
    compared++;
    if (act_v !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL full_start: got %h expected %h", act_v, exp_v);
    end
    for (int i = 0; i < 26; i++) begin
      drive_cycle(1'b0, i < 24);
      exp_v = sb.pop_front();
      act_v = observed();
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL full_frame[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      if (line_done)  n_line++;
      if (plane_done) n_plane++;
      if (frame_done) begin
        n_frame++;
        frame_at = i;
      end
    end
    compared++;
    if (n_line != 6) begin
      mismatched++;
      $display("[TB] FAIL line_count: got %0d expected 6", n_line);
    end
    compared++;
    if (n_plane != 2) begin
      mismatched++;
      $display("[TB] FAIL plane_count: got %0d expected 2", n_plane);
    end
    compared++;
    if (n_frame != 1 || frame_at != 23) begin
      mismatched++;
      $display("[TB] FAIL frame_pulse: got count %0d at %0d expected 1 at 23", n_frame, frame_at);
    end
`ifdef FRAME_SCAN_AUTORESTART_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    compared++;
    if (busy !== exp_busy) begin
      mismatched++;
      $display("[TB] FAIL end_busy: got %b expected %b", busy, exp_busy);
    end
  endtask

  task automatic test_toggle();
    int frame_at = -1;
    drive_cycle(1'b1, 1'b0);
    exp_v = sb.pop_front();
    act_v = observed();
    compared++;
    if (act_v !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL toggle_start: got %h expected %h", act_v, exp_v);
    end
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b0, (i % 2) == 0 && i < 48);
      exp_v = sb.pop_front();
      act_v = observed();
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL toggle[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      if (frame_done) frame_at = i;
    end
    compared++;
    if (frame_at != 46) begin
      mismatched++;
      $display("[TB] FAIL toggle_frame_cycle: got %0d expected 46", frame_at);
    end
  endtask

  task automatic test_start_in_run();
    int frame_at = -1;
    drive_cycle(1'b1, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 25; i++) begin
      drive_cycle(i == 9, i < 24);
      exp_v = sb.pop_front();
      act_v = observed();
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL start_in_run[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      if (frame_done) frame_at = i;
    end
    compared++;
    if (frame_at != 23) begin
      mismatched++;
      $display("[TB] FAIL start_in_run_frame: got %0d expected 23", frame_at);
    end
  endtask

  task automatic test_midframe_reset();
    drive_cycle(1'b1, 1'b0);
    void'(sb.pop_front());
    for (int i = 0; i < 18; i++) begin
      drive_cycle(1'b0, 1'b1);
      void'(sb.pop_front());
    end
    compared++;
    if ({busy, ch, row, col} !== {1'b1, 8'd1, 15'd1, 15'd2}) begin
      mismatched++;
      $display("[TB] FAIL midframe_position: got busy %b ch %0d row %0d col %0d expected 1 1 1 2",
               busy, ch, row, col);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (observed() !== 42'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %h expected %h", observed(), 42'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i == 2, i != 2);
      exp_v = sb.pop_front();
      act_v = observed();
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL post_reset[%0d]: got %h expected %h", i, act_v, exp_v);
      end
    end
  endtask

  initial begin
    start   = 1'b0;
    adv     = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_idle_adv();
    test_full_frame();
    test_toggle();
    test_start_in_run();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
